bcd_countdown_ctrl: RTL

Control and datapath stage between the debounced one-pulse push-button outputs and the scan controller / 7-segment decoder of the 25-second stopwatch. It merges start/pause/clear control with a 2-digit BCD down-counter in the system clock domain, using a 1 Hz tick enable instead of a derived clock. It drives digit1/digit0 to the scan stage, plus run/done status for the LEDs.

---
 rtl/bcd_countdown_ctrl_pkg.sv | 18 +
 rtl/bcd_countdown_ctrl_bcd_down2.sv | 57 +++++
 rtl/bcd_countdown_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/bcd_countdown_ctrl_pkg.sv
// Shared widths, BCD constants and state encoding for the 25-second
// stopwatch countdown block.
package bcd_countdown_ctrl_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
    localparam logic [BCD_BIT_WIDTH-1:0] BCD_ONE  = 4'd1;
    localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        CD_IDLE  = 2'd0,
        CD_RUN   = 2'd1,
        CD_PAUSE = 2'd2,
        CD_DONE  = 2'd3
    } cd_state_t;

endpackage

// File: rtl/bcd_countdown_ctrl_bcd_down2.sv
// Two-digit BCD down-counter with synchronous load and a saturating
// decrement; reset loads the preset value given by parameters.
module bcd_down2
    import bcd_countdown_ctrl_pkg::*;
#(
    parameter logic [BCD_BIT_WIDTH-1:0] RST_TENS = 4'd2,
    parameter logic [BCD_BIT_WIDTH-1:0] RST_ONES = 4'd5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     dec,
    input  logic [BCD_BIT_WIDTH-1:0] load_tens,
    input  logic [BCD_BIT_WIDTH-1:0] load_ones,
    output logic [BCD_BIT_WIDTH-1:0] digit1,
    output logic [BCD_BIT_WIDTH-1:0] digit0,
    output logic                     is_one,
    output logic                     is_zero
);

    logic [BCD_BIT_WIDTH-1:0] digit1_q, digit1_d;
    logic [BCD_BIT_WIDTH-1:0] digit0_q, digit0_d;

    assign is_zero = (digit1_q == BCD_ZERO) && (digit0_q == BCD_ZERO);
    assign is_one  = (digit1_q == BCD_ZERO) && (digit0_q == BCD_ONE);

    // Decrement saturates at 00 so the count can never wrap to 99.
    always_comb begin
        digit1_d = digit1_q;
        digit0_d = digit0_q;
        if (load) begin
            digit1_d = load_tens;
            digit0_d = load_ones;
        end else if (dec && !is_zero) begin
            if (digit0_q != BCD_ZERO) begin
                digit0_d = digit0_q - BCD_ONE;
            end else begin
                digit0_d = BCD_NINE;
                digit1_d = digit1_q - BCD_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit1_q <= RST_TENS;
            digit0_q <= RST_ONES;
        end else begin
            digit1_q <= digit1_d;
            digit0_q <= digit0_d;
        end
    end

    assign digit1 = digit1_q;
    assign digit0 = digit0_q;

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Start/pause/clear control FSM around a 2-digit BCD down-counter, advanced
// by a 1 Hz enable in the system clock domain.
module bcd_countdown_ctrl
    import bcd_countdown_ctrl_pkg::*;
#(
    parameter logic [BCD_BIT_WIDTH-1:0] PRESET_TENS = 4'd2,
    parameter logic [BCD_BIT_WIDTH-1:0] PRESET_ONES = 4'd5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_1hz,
    input  logic                     pb_start,
    input  logic                     pb_clear,
    output logic [BCD_BIT_WIDTH-1:0] digit1,
    output logic [BCD_BIT_WIDTH-1:0] digit0,
    output logic                     running,
    output logic                     done,
    output logic                     done_pulse
);

    cd_state_t state_q, state_d;
    logic      done_pulse_q, done_pulse_d;
    logic      load, dec, is_one, is_zero;

    bcd_down2 #(
        .RST_TENS(PRESET_TENS),
        .RST_ONES(PRESET_ONES)
    ) u_count (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .load_tens(PRESET_TENS),
        .load_ones(PRESET_ONES),
        .digit1   (digit1),
        .digit0   (digit0),
        .is_one   (is_one),
        .is_zero  (is_zero)
    );

    // Clear outranks start, which outranks the tick.
    always_comb begin
        state_d      = state_q;
        done_pulse_d = 1'b0;
        load         = 1'b0;
        dec          = 1'b0;
        if (pb_clear) begin
            state_d = CD_IDLE;
            load    = 1'b1;
        end else begin
            unique case (state_q)
                CD_IDLE: begin
                    if (pb_start) begin
                        if (is_zero) begin
                            state_d      = CD_DONE;
                            done_pulse_d = 1'b1;
                        end else begin
                            state_d = CD_RUN;
                        end
                    end
                end
                CD_RUN: begin
                    if (pb_start) begin
                        state_d = CD_PAUSE;
                    end else if (tick_1hz) begin
                        dec = 1'b1;
                        if (is_one) begin
                            state_d      = CD_DONE;
                            done_pulse_d = 1'b1;
                        end
                    end
                end
                CD_PAUSE: begin
                    if (pb_start) begin
                        state_d = CD_RUN;
                    end
                end
                CD_DONE: begin
                    state_d = CD_DONE;
                end
                default: state_d = CD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CD_IDLE;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign running    = (state_q == CD_RUN);
    assign done       = (state_q == CD_DONE);
    assign done_pulse = done_pulse_q;

endmodule
